// File: rtl/round_constants_if.sv
// Bus bundle for the Anubis round-constant generator: the round index goes in,
// the registered 128-bit constant matrix comes out.
interface round_constants_if;
  logic [3:0]   round_counter;
  logic [127:0] data_out;

  modport master (output round_counter, input data_out);
  modport slave  (input round_counter, output data_out);
endinterface

// File: rtl/round_constants.sv
// Anubis round-constant generator (128-bit key, N = 4): maps round index r to
// the constant matrix c^r, registered, with row 0 holding S[4(r-1)..4(r-1)+3].
module round_constants (
  input  logic               clk,
  input  logic               rst_n,
  round_constants_if.slave   bus
);

  // First 56 Anubis S-box bytes; byte k sits at bits [447-8k -: 8].
  localparam logic [447:0] SBOX_ROM = {
    32'ha7d3e671, 32'hd0ac4d79, 32'h3ac991fc, 32'h1e4754bd,
    32'h8ca57afb, 32'h63b8ddd4, 32'he5b3c5be, 32'ha9880ca2,
    32'h39df29da, 32'h2ba8cb4c, 32'h4b22aa24, 32'h4170a6f9,
    32'h5ae2b036, 32'h7de433ff
  };

  function automatic logic [7:0] sbox_byte(input logic [5:0] k);
    sbox_byte = SBOX_ROM[9'd447 - {k, 3'b000} -: 8];
  endfunction

  logic [5:0]   base;
  logic [127:0] data_d;
  logic [127:0] data_q;

  always_comb begin
    base   = {bus.round_counter - 4'd1, 2'b00};
    data_d = '0;
    // Indices 0 and 15 fall outside the ROM and leave the matrix all-zero.
    if (bus.round_counter >= 4'd1 && bus.round_counter <= 4'd14) begin
      data_d[127:96] = {sbox_byte(base),         sbox_byte(base + 6'd1),
                        sbox_byte(base + 6'd2),  sbox_byte(base + 6'd3)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bus.data_out = data_q;

endmodule

// File: tb/tb_round_constants.sv
// Bench for round_constants: directed reset/sweep/edge/hold cases plus random
// indices, all checked against a word-table reference model.
module tb_round_constants;

  logic clk;
  logic rst_n;

  round_constants_if bus ();

  round_constants dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [127:0] exp_q[$];

  // Reference: the published RC word for r = 1..14 in row 0, everything else zero.
  logic [31:0] rc_table [16];
  initial begin
    rc_table[0]  = 32'h0;
    rc_table[1]  = 32'ha7d3e671; rc_table[2]  = 32'hd0ac4d79;
    rc_table[3]  = 32'h3ac991fc; rc_table[4]  = 32'h1e4754bd;
    rc_table[5]  = 32'h8ca57afb; rc_table[6]  = 32'h63b8ddd4;
    rc_table[7]  = 32'he5b3c5be; rc_table[8]  = 32'ha9880ca2;
    rc_table[9]  = 32'h39df29da; rc_table[10] = 32'h2ba8cb4c;
    rc_table[11] = 32'h4b22aa24; rc_table[12] = 32'h4170a6f9;
    rc_table[13] = 32'h5ae2b036; rc_table[14] = 32'h7de433ff;
    rc_table[15] = 32'h0;
  end

  function automatic logic [127:0] model(input int r);
    logic [127:0] m;
    m = 128'h0;
    if (r >= 1 && r <= 14) m = {rc_table[r], 96'h0};
    return m;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %032h expected %032h", tag, obs, exp);
    end
  endtask

  // Driver: apply an index, then check the constant one edge later.
  task automatic step(input int r, input string tag);
    logic [127:0] e;
    @(negedge clk);
    bus.round_counter = 4'(r);
    exp_q.push_back(model(r));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, bus.data_out, e);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.round_counter = 4'd1;

    // Reset held across clock edges.
    repeat (3) @(posedge clk);
    #1 check_eq("reset_hold", bus.data_out, 128'h0);
    @(negedge clk);
    check_eq("reset_hold_neg", bus.data_out, 128'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("reset_release", bus.data_out,
                128'ha7d3e671_00000000_00000000_00000000);

    for (int r = 1; r <= 14; r++) step(r, $sformatf("sweep_r%0d", r));

    step(0,  "oor_r0");
    step(15, "oor_r15");

    step(12, "edge_r12");
    step(13, "edge_r13");
    step(14, "edge_r14");
    step(1,  "wrap_r1");

    // Asynchronous reset between edges while r = 8 is on the output.
    step(8, "mid_r8");
    #1 rst_n = 1'b0;
    #1 check_eq("async_clear", bus.data_out, 128'h0);
    @(negedge clk);
    check_eq("async_clear_held", bus.data_out, 128'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("async_restore", bus.data_out, model(8));

    // Hold r = 5, checking on both clock phases for stability.
    for (int i = 0; i < 10; i++) begin
      step(5, $sformatf("hold_%0d", i));
      @(negedge clk);
      check_eq($sformatf("hold_neg_%0d", i), bus.data_out,
               128'h8ca57afb_00000000_00000000_00000000);
    end

    for (int i = 0; i < 200; i++) step(int'($urandom_range(0, 15)), "random");

    if (exp_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
